// File: rtl/dcache_top_if.sv
// Bundle of the dcache stage's ALU request, writeback response and main-memory line buses.
// The slave modport is the cache's view; master is the surrounding pipeline and memory.
interface dcache_top_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      req_valid;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic                      req_size;
  logic                      req_is_store;
  logic [DATA_WIDTH-1:0]     req_data;
  logic                      req_m_type_instr;
  logic                      req_r_type_instr;
  logic [REG_ADDR_WIDTH-1:0] req_dst_reg;
  logic                      dcache_busy;
  logic                      rsp_wb_valid;
  logic                      rsp_wb_write_rf;
  logic [REG_ADDR_WIDTH-1:0] rsp_wb_dst_reg;
  logic [DATA_WIDTH-1:0]     rsp_wb_data;
  logic [DATA_WIDTH-1:0]     cache_data_bypass;
  logic                      xcpt_misaligned;
  logic                      req_mm_valid;
  logic                      req_mm_is_store;
  logic [ADDR_WIDTH-1:0]     req_mm_addr;
  logic [LINE_WIDTH-1:0]     req_mm_data;
  logic                      rsp_mm_valid;
  logic [LINE_WIDTH-1:0]     rsp_mm_data;

  modport slave (
    input  req_valid, req_addr, req_size, req_is_store, req_data, req_m_type_instr,
           req_r_type_instr, req_dst_reg, rsp_mm_valid, rsp_mm_data,
    output dcache_busy, rsp_wb_valid, rsp_wb_write_rf, rsp_wb_dst_reg, rsp_wb_data,
           cache_data_bypass, xcpt_misaligned, req_mm_valid, req_mm_is_store, req_mm_addr,
           req_mm_data
  );

  modport master (
    output req_valid, req_addr, req_size, req_is_store, req_data, req_m_type_instr,
           req_r_type_instr, req_dst_reg, rsp_mm_valid, rsp_mm_data,
    input  dcache_busy, rsp_wb_valid, rsp_wb_write_rf, rsp_wb_dst_reg, rsp_wb_data,
           cache_data_bypass, xcpt_misaligned, req_mm_valid, req_mm_is_store, req_mm_addr,
           req_mm_data
  );
endinterface

// File: rtl/dcache_top.sv
// Direct-mapped, write-back, write-allocate data cache stage; R-type results pass through.
// Misses walk IDLE -> (EVICT) -> FILL -> RESP, replaying the captured request in RESP.
module dcache_top #(
  parameter int unsigned DCACHE_LINES   = 4,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input logic         clock,
  input logic         reset,
  dcache_top_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IDX_W = $clog2(DCACHE_LINES);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - OFF_W;

  typedef enum logic [1:0] {StIdle, StEvict, StFill, StResp} state_e;

  state_e                    r_state;
  logic [DCACHE_LINES-1:0]   r_valid;
  logic [DCACHE_LINES-1:0]   r_dirty;
  logic [TAG_W-1:0]          r_tag  [DCACHE_LINES];
  logic [LINE_WIDTH-1:0]     r_data [DCACHE_LINES];
  logic [ADDR_WIDTH-1:0]     r_cap_addr;
  logic                      r_cap_size;
  logic                      r_cap_store;
  logic [DATA_WIDTH-1:0]     r_cap_data;
  logic [REG_ADDR_WIDTH-1:0] r_cap_dst;
  logic                      r_wb_valid;
  logic                      r_wb_write_rf;
  logic [REG_ADDR_WIDTH-1:0] r_wb_dst;
  logic [DATA_WIDTH-1:0]     r_wb_data;
  logic                      r_xcpt;
  logic                      r_mm_valid;
  logic                      r_mm_store;
  logic [ADDR_WIDTH-1:0]     r_mm_addr;
  logic [LINE_WIDTH-1:0]     r_mm_data;

  logic                      w_use_cap;
  logic [ADDR_WIDTH-1:0]     w_addr;
  logic                      w_size;
  logic                      w_store;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [REG_ADDR_WIDTH-1:0] w_dst;
  logic [IDX_W-1:0]          w_idx;
  logic [OFF_W-1:0]          w_off;
  logic [TAG_W-1:0]          w_tag;
  logic [LINE_WIDTH-1:0]     w_line;
  logic [LINE_WIDTH-1:0]     w_merged;
  logic [DATA_WIDTH-1:0]     w_ld;
  logic                      w_hit;
  logic                      w_misaligned;
  logic                      w_accept;
  logic                      w_miss;
  logic                      w_do_op;

  // Outside IDLE the datapath works on the captured request, so RESP reuses the hit logic.
  assign w_use_cap    = (r_state != StIdle);
  assign w_addr       = w_use_cap ? r_cap_addr  : bus.req_addr;
  assign w_size       = w_use_cap ? r_cap_size  : bus.req_size;
  assign w_store      = w_use_cap ? r_cap_store : bus.req_is_store;
  assign w_data       = w_use_cap ? r_cap_data  : bus.req_data;
  assign w_dst        = w_use_cap ? r_cap_dst   : bus.req_dst_reg;
  assign w_idx        = w_addr[OFF_W +: IDX_W];
  assign w_off        = w_addr[OFF_W-1:0];
  assign w_tag        = w_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_line       = r_data[w_idx];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_misaligned = w_size && (w_addr[1:0] != 2'b00);
  assign w_accept     = bus.req_valid && (r_state == StIdle);
  assign w_miss       = w_accept && bus.req_m_type_instr && !w_misaligned && !w_hit;
  assign w_do_op      = (r_state == StResp) ||
                        (w_accept && bus.req_m_type_instr && !w_misaligned && w_hit);

  always_comb begin
    w_merged = w_line;
    if (w_size) begin
      w_ld = w_line[w_off[OFF_W-1:2] * DATA_WIDTH +: DATA_WIDTH];
      w_merged[w_off[OFF_W-1:2] * DATA_WIDTH +: DATA_WIDTH] = w_data;
    end else begin
      w_ld = {{(DATA_WIDTH-8){1'b0}}, w_line[{w_off, 3'b000} +: 8]};
      w_merged[{w_off, 3'b000} +: 8] = w_data[7:0];
    end
  end

  // Data/tag arrays are deliberately left out of the reset branch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_cap_addr    <= '0;
      r_cap_size    <= 1'b0;
      r_cap_store   <= 1'b0;
      r_cap_data    <= '0;
      r_cap_dst     <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_write_rf <= 1'b0;
      r_wb_dst      <= '0;
      r_wb_data     <= '0;
      r_xcpt        <= 1'b0;
      r_mm_valid    <= 1'b0;
      r_mm_store    <= 1'b0;
      r_mm_addr     <= '0;
      r_mm_data     <= '0;
    end else begin
      r_wb_valid    <= 1'b0;
      r_wb_write_rf <= 1'b0;
      r_xcpt        <= 1'b0;
      if (w_do_op) begin
        r_wb_valid <= 1'b1;
        if (w_store) begin
          r_data[w_idx]  <= w_merged;
          r_dirty[w_idx] <= 1'b1;
        end else begin
          r_wb_write_rf <= 1'b1;
          r_wb_data     <= w_ld;
          r_wb_dst      <= w_dst;
        end
      end
      case (r_state)
        StIdle: begin
          if (w_accept && bus.req_m_type_instr) begin
            if (w_misaligned) begin
              r_wb_valid <= 1'b1;
              r_xcpt     <= 1'b1;
            end else if (!w_hit) begin
              r_cap_addr  <= bus.req_addr;
              r_cap_size  <= bus.req_size;
              r_cap_store <= bus.req_is_store;
              r_cap_data  <= bus.req_data;
              r_cap_dst   <= bus.req_dst_reg;
              r_mm_valid  <= 1'b1;
              if (r_valid[w_idx] && r_dirty[w_idx]) begin
                r_state    <= StEvict;
                r_mm_store <= 1'b1;
                r_mm_addr  <= {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
                r_mm_data  <= w_line;
              end else begin
                r_state    <= StFill;
                r_mm_store <= 1'b0;
                r_mm_addr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
              end
            end
          end else if (w_accept && bus.req_r_type_instr) begin
            r_wb_valid    <= 1'b1;
            r_wb_write_rf <= 1'b1;
            r_wb_data     <= bus.req_data;
            r_wb_dst      <= bus.req_dst_reg;
          end
        end
        StEvict: begin
          if (bus.rsp_mm_valid) begin
            r_state    <= StFill;
            r_mm_store <= 1'b0;
            r_mm_addr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
          end
        end
        StFill: begin
          if (bus.rsp_mm_valid) begin
            r_state        <= StResp;
            r_mm_valid     <= 1'b0;
            r_data[w_idx]  <= bus.rsp_mm_data;
            r_tag[w_idx]   <= w_tag;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.dcache_busy       = reset && ((r_state != StIdle) || w_miss);
  assign bus.rsp_wb_valid      = r_wb_valid;
  assign bus.rsp_wb_write_rf   = r_wb_write_rf;
  assign bus.rsp_wb_dst_reg    = r_wb_dst;
  assign bus.rsp_wb_data       = r_wb_data;
  assign bus.cache_data_bypass = r_wb_data;
  assign bus.xcpt_misaligned   = r_xcpt;
  assign bus.req_mm_valid      = r_mm_valid;
  assign bus.req_mm_is_store   = r_mm_store;
  assign bus.req_mm_addr       = r_mm_addr;
  assign bus.req_mm_data       = r_mm_data;
endmodule

// File: tb/tb_dcache_top.sv
// Scoreboard bench for dcache_top: directed requests push expected writeback and memory
// transactions into queues that independent monitor/memory processes pop and compare.
module tb_dcache_top;
  typedef struct {
    logic        wrf;
    logic        xcpt;
    logic [31:0] data;
    logic [4:0]  dst;
  } rsp_t;

  typedef struct {
    logic         st;
    logic [31:0]  addr;
    logic [127:0] data;
  } mm_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic mm_stall;
  rsp_t exp_q[$];
  mm_t  mm_q[$];
  logic [127:0] mem [int];

  dcache_top_if bus ();

  dcache_top dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rsp(input logic wrf, input logic xcpt, input logic [31:0] d,
                          input logic [4:0] dst);
    rsp_t e;
    e.wrf = wrf; e.xcpt = xcpt; e.data = d; e.dst = dst;
    exp_q.push_back(e);
  endtask

  task automatic push_mm(input logic st, input logic [31:0] a, input logic [127:0] d);
    mm_t e;
    e.st = st; e.addr = a; e.data = d;
    mm_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.dcache_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_release", {127'b0, bus.dcache_busy}, 128'd0);
  endtask

  task automatic issue(input logic m, input logic r, input logic st, input logic sz,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst,
                       input logic exp_busy);
    @(posedge clk); #1;
    bus.req_valid        = 1'b1;
    bus.req_m_type_instr = m;
    bus.req_r_type_instr = r;
    bus.req_is_store     = st;
    bus.req_size         = sz;
    bus.req_addr         = a;
    bus.req_data         = d;
    bus.req_dst_reg      = dst;
    @(negedge clk);
    check("busy_at_accept", {127'b0, bus.dcache_busy}, {127'b0, exp_busy});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_idle();
  endtask

  // Writeback monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_wb_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {127'b0, bus.rsp_wb_valid}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_xcpt", {127'b0, bus.xcpt_misaligned}, {127'b0, e.xcpt});
          check("rsp_write_rf", {127'b0, bus.rsp_wb_write_rf}, {127'b0, e.wrf});
          if (e.wrf) begin
            check("rsp_data", {96'b0, bus.rsp_wb_data}, {96'b0, e.data});
            check("rsp_dst", {123'b0, bus.rsp_wb_dst_reg}, {123'b0, e.dst});
            check("bypass", {96'b0, bus.cache_data_bypass}, {96'b0, e.data});
          end
        end
      end
    end
  end

  // Main-memory model: checks each request, acks two cycles later
  initial begin
    mm_t e;
    bus.rsp_mm_valid = 1'b0;
    bus.rsp_mm_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && !mm_stall && bus.req_mm_valid) begin
        if (mm_q.size() == 0) begin
          check("unexpected_mm", {127'b0, bus.req_mm_valid}, 128'd0);
        end else begin
          e = mm_q.pop_front();
          check("mm_is_store", {127'b0, bus.req_mm_is_store}, {127'b0, e.st});
          check("mm_addr", {96'b0, bus.req_mm_addr}, {96'b0, e.addr});
          if (e.st) check("mm_evict_data", bus.req_mm_data, e.data);
        end
        repeat (2) @(negedge clk);
        if (bus.req_mm_is_store) mem[int'(bus.req_mm_addr)] = bus.req_mm_data;
        else bus.rsp_mm_data = mem.exists(int'(bus.req_mm_addr)) ?
                               mem[int'(bus.req_mm_addr)] : 128'd0;
        bus.rsp_mm_valid = 1'b1;
        @(negedge clk);
        bus.rsp_mm_valid = 1'b0;
      end
    end
  end

  initial begin
    n_checks             = 0;
    n_fail               = 0;
    mm_stall             = 1'b0;
    rst_n                = 1'b0;
    bus.req_valid        = 1'b0;
    bus.req_addr         = '0;
    bus.req_size         = 1'b0;
    bus.req_is_store     = 1'b0;
    bus.req_data         = '0;
    bus.req_m_type_instr = 1'b0;
    bus.req_r_type_instr = 1'b0;
    bus.req_dst_reg      = '0;
    mem[32'h40] = 128'h33333333_22222222_11111111_DEADBEEF;
    mem[32'h80] = 128'h88888888_77777777_66666666_55555555;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_wb_valid", {127'b0, bus.rsp_wb_valid}, 128'd0);
    check("reset_busy", {127'b0, bus.dcache_busy}, 128'd0);
    check("reset_mm_valid", {127'b0, bus.req_mm_valid}, 128'd0);
    check("reset_xcpt", {127'b0, bus.xcpt_misaligned}, 128'd0);
    check("reset_wb_data", {96'b0, bus.rsp_wb_data}, 128'd0);

    // R-type pass-through
    push_rsp(1'b1, 1'b0, 32'h0000_1234, 5'd3);
    issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_1234, 5'd3, 1'b0);

    // Cold word load, then hit
    push_mm(1'b0, 32'h40, 128'd0);
    push_rsp(1'b1, 1'b0, 32'hDEADBEEF, 5'd5);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 5'd5, 1'b1);
    push_rsp(1'b1, 1'b0, 32'hDEADBEEF, 5'd6);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 5'd6, 1'b0);

    // Byte store merge and byte/word loads
    push_rsp(1'b0, 1'b0, 32'h0, 5'd0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h41, 32'h0000_00AA, 5'd0, 1'b0);
    push_rsp(1'b1, 1'b0, 32'h0000_00AA, 5'd7);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h41, 32'h0, 5'd7, 1'b0);
    push_rsp(1'b1, 1'b0, 32'hDEADAAEF, 5'd8);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 5'd8, 1'b0);
    push_rsp(1'b1, 1'b0, 32'h33333333, 5'd9);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h4C, 32'h0, 5'd9, 1'b0);

    // Dirty eviction: word store, then conflicting load at 0x80
    push_rsp(1'b0, 1'b0, 32'h0, 5'd0);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 5'd0, 1'b0);
    push_mm(1'b1, 32'h40, 128'h33333333_22222222_11111111_CAFEF00D);
    push_mm(1'b0, 32'h80, 128'd0);
    push_rsp(1'b1, 1'b0, 32'h55555555, 5'd10);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h0, 5'd10, 1'b1);

    // Clean victim: refill 0x40 from written-back memory, no evict
    push_mm(1'b0, 32'h40, 128'd0);
    push_rsp(1'b1, 1'b0, 32'h000000CA, 5'd11);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h43, 32'h0, 5'd11, 1'b1);

    // Misaligned word accesses: hit line and cold line
    push_rsp(1'b0, 1'b1, 32'h0, 5'd0);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h42, 32'h0, 5'd12, 1'b0);
    push_rsp(1'b0, 1'b1, 32'h0, 5'd0);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'hC3, 32'h0, 5'd13, 1'b0);

    // No-type request produces no response
    issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 5'd14, 1'b0);

    // Reset in the middle of a fill
    mm_stall = 1'b1;
    @(posedge clk); #1;
    bus.req_valid        = 1'b1;
    bus.req_m_type_instr = 1'b1;
    bus.req_r_type_instr = 1'b0;
    bus.req_is_store     = 1'b0;
    bus.req_size         = 1'b1;
    bus.req_addr         = 32'h100;
    @(negedge clk);
    check("fill_busy", {127'b0, bus.dcache_busy}, 128'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("fill_mm_valid", {127'b0, bus.req_mm_valid}, 128'd1);
    check("fill_mm_addr", {96'b0, bus.req_mm_addr}, 128'h100);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mm_valid", {127'b0, bus.req_mm_valid}, 128'd0);
    check("abort_busy", {127'b0, bus.dcache_busy}, 128'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    mm_stall = 1'b0;
    push_mm(1'b0, 32'h40, 128'd0);
    push_rsp(1'b1, 1'b0, 32'hCAFEF00D, 5'd15);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 5'd15, 1'b1);

    repeat (4) @(negedge clk);
    check("rsp_queue_empty", 128'(exp_q.size()), 128'd0);
    check("mm_queue_empty", 128'(mm_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_top.md
Name: dcache_top

Overview:
- Data cache stage, directly downstream of the ALU stage.
- Consumes the registered ALU request: address, size, store flag and data, plus M-type/R-type flags and destination register.
- M-type requests are served by a direct-mapped, write-back, write-allocate cache backed by a main-memory line interface.
- R-type results pass through to the writeback stage unchanged. The stage drives the ALU stall and the cache-to-ALU bypass.

Parameters:
- DCACHE_LINES, 4, number of lines, power of 2.
- LINE_WIDTH, 128, bits per line.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, register file data width.
- REG_ADDR_WIDTH, 5, register file address width.

Ports:
- clock  in  1  stage clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  ALU request valid.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  1  0=Byte, 1=Word.
- req_is_store  in  1  store when 1.
- req_data  in  DATA_WIDTH  store data, or R-type result.
- req_m_type_instr  in  1  memory op.
- req_r_type_instr  in  1  integer result to retire.
- req_dst_reg  in  REG_ADDR_WIDTH  destination register.
- dcache_busy  out  1  stall to ALU (drives stall_alu).
- rsp_wb_valid  out  1  result to writeback.
- rsp_wb_write_rf  out  1  RF write enable (load or R-type).
- rsp_wb_dst_reg  out  REG_ADDR_WIDTH  RF address.
- rsp_wb_data  out  DATA_WIDTH  RF data.
- cache_data_bypass  out  DATA_WIDTH  equals rsp_wb_data.
- xcpt_misaligned  out  1  word access with addr[1:0]!=0.
- req_mm_valid  out  1  memory request.
- req_mm_is_store  out  1  line writeback when 1.
- req_mm_addr  out  ADDR_WIDTH  line-aligned address, low 4 bits zero.
- req_mm_data  out  LINE_WIDTH  evicted line.
- rsp_mm_valid  in  1  memory ack: store done, or fill data valid.
- rsp_mm_data  in  LINE_WIDTH  fill data.

Behaviour:
- Reset (reset low, async):
  - All valid/dirty bits cleared, FSM to IDLE.
  - All outputs 0; data arrays not reset.
- Address split: offset = addr[3:0], index = addr[5:4], tag = addr[31:6].
- Accept rule: a request is accepted when req_valid is high and the FSM is in IDLE.
- R-type request (req_r_type_instr=1):
  - Next cycle: rsp_wb_valid=1, rsp_wb_write_rf=1, rsp_wb_data=req_data, rsp_wb_dst_reg=req_dst_reg.
  - Never stalls.
- M-type hit (valid and tag match), 1-cycle latency:
  - Load: rsp_wb_write_rf=1.
    - Word load returns word addr[3:2].
    - Byte load returns byte addr[3:0], zero-extended to 32 bits.
  - Store: merges word or byte lane into the line and sets dirty; rsp_wb_valid=1 (retire), rsp_wb_write_rf=0.
- M-type miss, FSM IDLE -> (EVICT if line valid and dirty) -> FILL -> RESP -> IDLE:
  - EVICT: req_mm_valid=1, req_mm_is_store=1, addr={old_tag,index,4'b0}, data=line. Held until rsp_mm_valid.
  - FILL: req_mm_valid=1, req_mm_is_store=0, addr={tag,index,4'b0}. Held until rsp_mm_valid. On that cycle the line is written with valid=1, dirty=0.
  - RESP: performs the hit operation on the captured request. Outputs appear the following cycle.
- dcache_busy:
  - Asserted combinationally in the cycle a miss is detected.
  - Stays high through EVICT/FILL/RESP; deasserts in the cycle the response registers load.
- Request capture: on miss the request is registered. Inputs are ignored while busy.
- Misaligned word access: xcpt_misaligned=1 with rsp_wb_valid=1 next cycle. No cache or memory action, rsp_wb_write_rf=0.
- req_m_type_instr and req_r_type_instr both 0 with req_valid: no response.
- Output lifetime: response outputs are single-cycle pulses. rsp_wb_data/rsp_wb_dst_reg hold their last value.
- Reset mid-miss: the FSM aborts to IDLE, req_mm_valid drops immediately, and pending state is lost.
- rsp_mm_valid in IDLE is ignored.

Test Plan:
- R-type: req_data=0x0000_1234, dst=3 -> next cycle rsp_wb_valid=1, write_rf=1, data=0x1234, dst=3; busy stays 0.
- Cold load word @0x40:
  - busy=1; FILL req_mm_addr=0x40, is_store=0.
  - Memory returns line with word0=0xDEADBEEF -> rsp_wb_data=0xDEADBEEF.
  - Repeat load -> 1-cycle hit, no mm request.
- Store byte 0xAA @0x41 after fill, then load byte @0x41 -> 0x000000AA; load word @0x40 -> 0xDEADAAEF.
- Dirty eviction:
  - Store to 0x40, then load 0x80 (same index 0).
  - EVICT with req_mm_addr=0x40 and the modified line, then FILL at 0x80; rsp after the fill ack.
- Load word @0x42 -> xcpt_misaligned=1, write_rf=0, no req_mm_valid.
- Assert reset during FILL -> req_mm_valid=0 and busy=0 immediately. Subsequent load @0x40 misses again.
